// File: rtl/av_pkg.sv
`default_nettype none
// ============================================================================
// Module      : av_pkg
// Description : Shared constants and helpers for the Avalon-MM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package av_pkg;

  // Address bit selecting the register window (1) or the RAM (0)
  localparam int AV_REGION_BIT = 31;

  // Register window word offsets (address bits [3:2])
  localparam logic [1:0] AV_IRQ_SET    = 2'd0;
  localparam logic [1:0] AV_IRQ_CLR    = 2'd1;
  localparam logic [1:0] AV_IRQ_STATUS = 2'd2;
  localparam logic [1:0] AV_RSVD       = 2'd3;

  // Deepest read pipeline the responder supports
  localparam int RDLATENCY_MAX = 8;

  // Expand a 4-bit byteenable into a 32-bit bit mask
  function automatic logic [31:0] av_lane_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage : av_pkg
`default_nettype wire

// File: rtl/av_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : av_rd_pipe
// Description : LAT-stage valid+data delay line for read responses. Valid
//               bits are asynchronously cleared so no response survives a
//               reset; data output is forced to zero when not valid.
// Revision    : 1.0 - initial release
// ============================================================================
module av_rd_pipe
  import av_pkg::*;
#(
  parameter int LAT = 2,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic [LAT-1:0] valid_q;
  logic [W-1:0]   data_q [LAT];

  // Valid shift register; flushed on reset so in-flight reads are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Data shift register; contents are meaningless unless the matching valid is set
  always_ff @(posedge clk) begin
    data_q[0] <= data_i;
    for (int i = 1; i < LAT; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  // Output stage: data is zero whenever no response is being presented
  always_comb begin
    valid_o = valid_q[LAT-1];
    data_o  = valid_q[LAT-1] ? data_q[LAT-1] : '0;
  end

endmodule : av_rd_pipe
`default_nettype wire

// File: rtl/av_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : av_mem_responder
// Description : Avalon-MM responder: byte-lane word RAM plus an interrupt
//               register window (set/clear/status). Zero-wait-state writes,
//               fixed-latency pipelined reads, registered irq vector.
// Revision    : 1.0 - initial release
// ============================================================================
module av_mem_responder
  import av_pkg::*;
#(
  parameter int ADDRWIDTH     = 32,
  parameter int DATAWIDTH     = 32,
  parameter int MEMDEPTH_LOG2 = 10,
  parameter int RDLATENCY     = 2,
  parameter int IRQWIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDRWIDTH-1:0]   av_address,
  input  logic [DATAWIDTH/8-1:0] av_byteenable,
  input  logic                   av_write,
  input  logic [DATAWIDTH-1:0]   av_writedata,
  input  logic                   av_read,
  output logic [DATAWIDTH-1:0]   av_readdata,
  output logic                   av_readdatavalid,
  output logic [IRQWIDTH-1:0]    irq
);

  localparam int MEMDEPTH = 1 << MEMDEPTH_LOG2;
  localparam int NLANES   = DATAWIDTH / 8;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic                     w_is_reg;
  logic [MEMDEPTH_LOG2-1:0] w_word_idx;
  logic [1:0]               w_reg_off;
  logic                     w_addr_unused;

  // Split the byte address into region, RAM word index and register offset
  always_comb begin
    w_is_reg      = av_address[AV_REGION_BIT];
    w_word_idx    = av_address[MEMDEPTH_LOG2+1:2];
    w_reg_off     = av_address[3:2];
    // High RAM bits alias and byte-offset bits are ignored by design
    w_addr_unused = ^{av_address[ADDRWIDTH-2:MEMDEPTH_LOG2+2], av_address[1:0]};
  end

  // --------------------------------------------------------------------------
  // Word RAM (not reset; read-before-write through the asynchronous read port)
  // --------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] mem_q [MEMDEPTH];
  logic [DATAWIDTH-1:0] w_ram_rdata;

  // Byte-lane write into the addressed RAM word
  always_ff @(posedge clk) begin
    if (av_write && !w_is_reg) begin
      for (int b = 0; b < NLANES; b++) begin
        if (av_byteenable[b]) begin
          mem_q[w_word_idx][b*8 +: 8] <= av_writedata[b*8 +: 8];
        end
      end
    end
  end

  // RAM read sees the pre-write contents of this cycle
  always_comb begin
    w_ram_rdata = mem_q[w_word_idx];
  end

  // --------------------------------------------------------------------------
  // Interrupt status register
  // --------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] w_lane_mask;
  logic [IRQWIDTH-1:0]  w_irq_wmask;
  logic [IRQWIDTH-1:0]  w_irq_wdata;
  logic [IRQWIDTH-1:0]  irq_d;
  logic [IRQWIDTH-1:0]  irq_q;

  // Next status: set/clear/overwrite only the byte lanes that are enabled
  always_comb begin
    w_lane_mask = av_lane_mask(av_byteenable);
    w_irq_wmask = w_lane_mask[IRQWIDTH-1:0];
    w_irq_wdata = av_writedata[IRQWIDTH-1:0] & w_irq_wmask;
    irq_d       = irq_q;
    if (av_write && w_is_reg) begin
      case (w_reg_off)
        AV_IRQ_SET:    irq_d = irq_q | w_irq_wdata;
        AV_IRQ_CLR:    irq_d = irq_q & ~w_irq_wdata;
        AV_IRQ_STATUS: irq_d = (irq_q & ~w_irq_wmask) | w_irq_wdata;
        default:       irq_d = irq_q;
      endcase
    end
  end

  // Status register; drives irq directly so there is no combinational path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

  // --------------------------------------------------------------------------
  // Read data select and response pipeline
  // --------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] w_status_ext;
  logic [DATAWIDTH-1:0] w_rd_data;

  // Choose RAM or register data; unimplemented status bits and RSVD read 0
  always_comb begin
    w_status_ext                 = '0;
    w_status_ext[IRQWIDTH-1:0]   = irq_q;
    w_rd_data                    = w_ram_rdata;
    if (w_is_reg) begin
      w_rd_data = (w_reg_off == AV_RSVD) ? '0 : w_status_ext;
    end
  end

  av_rd_pipe #(
    .LAT (RDLATENCY),
    .W   (DATAWIDTH)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (av_read),
    .data_i  (w_rd_data),
    .valid_o (av_readdatavalid),
    .data_o  (av_readdata)
  );

endmodule : av_mem_responder
`default_nettype wire

// File: tb/tb_av_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_av_mem_responder
// Description : Directed self-checking bench for av_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_av_mem_responder;

  localparam int RDLAT = 2;
  localparam int MEMLOG = 10;
  localparam int IRQW  = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] av_address = '0;
  logic [3:0]  av_byteenable = '0;
  logic        av_write = 1'b0;
  logic [31:0] av_writedata = '0;
  logic        av_read = 1'b0;
  logic [31:0] av_readdata;
  logic        av_readdatavalid;
  logic [IRQW-1:0] irq;

  int n_chk  = 0;
  int n_fail = 0;

  av_mem_responder #(
    .ADDRWIDTH     (32),
    .DATAWIDTH     (32),
    .MEMDEPTH_LOG2 (MEMLOG),
    .RDLATENCY     (RDLAT),
    .IRQWIDTH      (IRQW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .av_address       (av_address),
    .av_byteenable    (av_byteenable),
    .av_write         (av_write),
    .av_writedata     (av_writedata),
    .av_read          (av_read),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    av_address    = addr;
    av_writedata  = data;
    av_byteenable = be;
    av_write      = 1'b1;
    tick();
    av_write      = 1'b0;
    av_byteenable = '0;
  endtask

  // Single read: response must appear exactly RDLAT cycles after issue, for one cycle
  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    av_address = addr;
    av_read    = 1'b1;
    tick();
    av_read    = 1'b0;
    for (int k = 1; k < RDLAT; k++) begin
      check({tag, "_early_valid"}, {31'd0, av_readdatavalid}, 32'd0);
      tick();
    end
    check({tag, "_valid"}, {31'd0, av_readdatavalid}, 32'd1);
    check({tag, "_data"}, av_readdata, exp);
    tick();
    check({tag, "_valid_end"}, {31'd0, av_readdatavalid}, 32'd0);
    check({tag, "_data_end"}, av_readdata, 32'd0);
  endtask

  initial begin
    // 1: reset held for 5 cycles, outputs quiet throughout
    #2 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_irq", irq, 32'd0);
      check("rst_valid", {31'd0, av_readdatavalid}, 32'd0);
      check("rst_data", av_readdata, 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // 2: full write then byte-lane merge
    wr(32'h0000_0010, 32'hA5A5_5A5A, 4'hF);
    rd_check("ram_full", 32'h0000_0010, 32'hA5A5_5A5A);
    wr(32'h0000_0010, 32'h0000_FF00, 4'h2);
    rd_check("ram_lane1", 32'h0000_0010, 32'hA5A5_FF5A);

    // 3: back-to-back reads every cycle, order preserved
    wr(32'h0000_0000, 32'd1, 4'hF);
    wr(32'h0000_0004, 32'd2, 4'hF);
    wr(32'h0000_0008, 32'd3, 4'hF);
    wr(32'h0000_000C, 32'd4, 4'hF);
    for (int t = 0; t < 4 + RDLAT + 1; t++) begin
      int idx;
      logic exp_v;
      if (t < 4) begin
        av_read    = 1'b1;
        av_address = 32'(t * 4);
      end else begin
        av_read = 1'b0;
      end
      tick();
      idx   = t + 1 - RDLAT;
      exp_v = (idx >= 0) && (idx < 4);
      check("b2b_valid", {31'd0, av_readdatavalid}, {31'd0, exp_v});
      check("b2b_data", av_readdata, exp_v ? 32'(idx + 1) : 32'd0);
    end

    // 4: interrupt register window
    wr(32'h8000_0000, 32'h0000_0005, 4'hF);
    check("irq_set", irq, 32'h5);
    wr(32'h8000_0004, 32'h0000_0001, 4'hF);
    check("irq_clr", irq, 32'h4);
    rd_check("irq_status_rd", 32'h8000_0008, 32'h4);
    rd_check("irq_rsvd_rd", 32'h8000_000C, 32'h0);
    rd_check("irq_set_rd", 32'h8000_0000, 32'h4);
    wr(32'h8000_000C, 32'hFFFF_FFFF, 4'hF);
    check("irq_rsvd_wr", irq, 32'h4);

    // Simultaneous read and IRQ_SET write: read returns pre-write status
    av_address    = 32'h8000_0000;
    av_writedata  = 32'h0000_0003;
    av_byteenable = 4'hF;
    av_write      = 1'b1;
    av_read       = 1'b1;
    tick();
    av_write = 1'b0;
    av_read  = 1'b0;
    check("rw_irq_now", irq, 32'h7);
    for (int k = 1; k < RDLAT; k++) tick();
    check("rw_valid", {31'd0, av_readdatavalid}, 32'd1);
    check("rw_data", av_readdata, 32'h4);

    // Partial-lane IRQ_STATUS write only touches lane 0
    wr(32'h8000_0008, 32'hFFFF_FFFF, 4'h1);
    check("irq_status_lane0", irq, 32'h0000_00FF);
    wr(32'h8000_0008, 32'h1200_0000, 4'h8);
    check("irq_status_lane3", irq, 32'h1200_00FF);

    // 5: read in flight when reset asserts is discarded; irq cleared
    av_address = 32'h0000_0010;
    av_read    = 1'b1;
    tick();
    av_read = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("flush_irq", irq, 32'd0);
    check("flush_valid0", {31'd0, av_readdatavalid}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < RDLAT + 2; k++) begin
      tick();
      check("flush_valid", {31'd0, av_readdatavalid}, 32'd0);
    end

    // 6: upper RAM address bits alias onto the same word
    wr(32'h0000_1000, 32'h1234_5678, 4'hF);
    rd_check("alias", 32'h0000_0000, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_av_mem_responder
`default_nettype wire
